// File: rtl/sbox_stream_engine.sv
// Multi-lane AES SubBytes / InvSubBytes stream engine: one block in, LANES bytes per cycle, one block out.
// Optional SBOX_FLUSH_EN macro adds a synchronous active-high flush input that abandons the current block.
module sbox_stream_engine #(
    parameter int NBYTES = 16,
    parameter int LANES  = 1,
    parameter int CNTW   = 5
) (
    input  logic                clk,
    input  logic                rst,
`ifdef SBOX_FLUSH_EN
    input  logic                flush,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_inv,
    input  logic [8*NBYTES-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_data,
    output logic                out_inv,
    output logic                busy
);

    localparam int W  = 8 * NBYTES;
    localparam int GW = 8 * LANES;
    localparam int N  = NBYTES / LANES;

    // FIPS-197 tables; entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX_FWD_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [2047:0] SBOX_INV_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return SBOX_FWD_TBL[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return SBOX_INV_TBL[2047 - 8 * int'(x) -: 8];
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]      work_q, work_d;
    logic [W-1:0]      result_q, result_d;
    logic              mode_q, mode_d;
    logic [W-1:0]      out_data_q, out_data_d;
    logic              out_inv_q, out_inv_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic [GW-1:0]     sub_s;
    logic              flush_s;
    logic              accept_s;
    logic              last_s;

`ifdef SBOX_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // A flush in IDLE masks the registered ready so no block is taken that cycle.
    assign in_ready  = in_ready_q & ~flush_s;
    assign accept_s  = in_valid & in_ready;
    assign last_s    = (cnt_q == CNTW'(N - 1));
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_inv   = out_inv_q;
    assign busy      = busy_q;

    // Lane LUTs: substitute the lowest LANES bytes of the working register.
    always_comb begin
        sub_s = '0;
        for (int l = 0; l < LANES; l++) begin
            if (mode_q) begin
                sub_s[8*l +: 8] = sbox_inv(work_q[8*l +: 8]);
            end else begin
                sub_s[8*l +: 8] = sbox_fwd(work_q[8*l +: 8]);
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        result_d    = result_q;
        mode_d      = mode_q;
        out_data_d  = out_data_q;
        out_inv_d   = out_inv_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    work_d     = in_data;
                    mode_d     = in_inv;
                    cnt_d      = '0;
                    state_d    = ST_SUB;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_SUB: begin
                if (flush_s) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    work_d = work_q >> GW;
                    cnt_d  = cnt_q + CNTW'(1);
                    for (int g = 0; g < N; g++) begin
                        if (cnt_q == CNTW'(g)) begin
                            result_d[g*GW +: GW] = sub_s;
                        end else begin
                            result_d[g*GW +: GW] = result_q[g*GW +: GW];
                        end
                    end
                    // Only the completing write reaches the output register.
                    if (last_s) begin
                        state_d     = ST_DONE;
                        cnt_d       = '0;
                        out_data_d  = result_d;
                        out_inv_d   = mode_q;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ST_SUB;
                    end
                end
            end
            ST_DONE: begin
                if (flush_s || out_ready) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            result_q    <= '0;
            mode_q      <= 1'b0;
            out_data_q  <= '0;
            out_inv_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            result_q    <= result_d;
            mode_q      <= mode_d;
            out_data_q  <= out_data_d;
            out_inv_q   <= out_inv_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

endmodule
